// File: rtl/led_blinker_pkg.sv
// led_blinker_pkg: shared mode encoding and tick period constants for the LED blinker
package led_blinker_pkg;
    typedef enum logic [1:0] {OFF = 2'b00, BLINK = 2'b01, PWM = 2'b10, PULSE = 2'b11} mode_t;
    localparam int HALF_PERIOD_SIM = 32;
    localparam int HALF_PERIOD_SYN = 32000000;
`ifdef SIMULATION
    localparam int HALF_PERIOD_DEF = HALF_PERIOD_SIM;
`else
    localparam int HALF_PERIOD_DEF = HALF_PERIOD_SYN;
`endif
endpackage

// File: rtl/rst_sync.sv
// rst_sync: asynchronous-assert, synchronous-deassert reset synchronizer
module rst_sync (
    input  logic pixel_clk,
    input  logic sys_rst,
    output logic pixel_rst
);
    logic [1:0] sync_q;
    // Two flops so release happens on the second clock edge after sys_rst falls
    always_ff @(posedge pixel_clk or posedge sys_rst)
        if (sys_rst) sync_q <= 2'b11;
        else         sync_q <= {sync_q[0], 1'b0};
    assign pixel_rst = sync_q[1];
endmodule

// File: rtl/led_blinker.sv
// led_blinker: multi-channel LED driver with off/blink/PWM/one-shot modes
module led_blinker
    import led_blinker_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int HALF_PERIOD = HALF_PERIOD_DEF,
    parameter int CNT_W       = 27,
    parameter int PWM_W       = 4,
    parameter int PULSE_TICKS = 3
) (
    input  logic                   pixel_clk,
    input  logic                   sys_rst,
    input  logic [2*NCH-1:0]       mode,
    input  logic [PWM_W*NCH-1:0]   duty,
    input  logic [NCH-1:0]         trig,
    output logic                   pixel_rst,
    output logic                   tick,
    output logic [NCH-1:0]         led,
    output logic [NCH-1:0]         busy
);
    localparam int TW = $clog2(PULSE_TICKS + 1);
    logic [CNT_W-1:0] presc;
    logic [PWM_W-1:0] pwm_cnt;
    rst_sync u_rst_sync (
        .pixel_clk (pixel_clk),
        .sys_rst   (sys_rst),
        .pixel_rst (pixel_rst)
    );
    assign tick = presc == CNT_W'(HALF_PERIOD - 1);
    // Shared prescaler and free-running PWM counter
    always_ff @(posedge pixel_clk or posedge pixel_rst)
        if (pixel_rst) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else begin
            presc   <= tick ? '0 : presc + CNT_W'(1);
            pwm_cnt <= pwm_cnt + PWM_W'(1);
        end
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [1:0]    prev_mode;
        logic          trig_q, led_q, busy_q, chg, fire;
        logic [TW-1:0] tcnt;
        mode_t         m;
        assign m    = mode_t'(mode[2*k +: 2]);
        assign chg  = mode[2*k +: 2] != prev_mode;
        assign fire = trig[k] & ~trig_q;
        assign led[k]  = led_q;
        assign busy[k] = busy_q;
        // A mode change wipes the channel for one cycle, swallowing any coincident trigger
        always_ff @(posedge pixel_clk or posedge pixel_rst)
            if (pixel_rst) begin
                prev_mode <= '0;
                trig_q    <= 1'b0;
                led_q     <= 1'b0;
                busy_q    <= 1'b0;
                tcnt      <= '0;
            end else begin
                prev_mode <= m;
                trig_q    <= trig[k];
                if (chg) begin
                    led_q  <= 1'b0;
                    busy_q <= 1'b0;
                    tcnt   <= '0;
                end else begin
                    case (m)
                        OFF: begin
                            led_q  <= 1'b0;
                            busy_q <= 1'b0;
                            tcnt   <= '0;
                        end
                        BLINK: begin
                            if (tick) led_q <= ~led_q;
                            busy_q <= 1'b0;
                        end
                        PWM: begin
                            led_q  <= pwm_cnt < duty[PWM_W*k +: PWM_W];
                            busy_q <= 1'b0;
                        end
                        PULSE: begin
                            if (busy_q) begin
                                if (tick) begin
                                    tcnt <= tcnt - TW'(1);
                                    if (tcnt == TW'(1)) begin
                                        led_q  <= 1'b0;
                                        busy_q <= 1'b0;
                                    end
                                end
                            end else if (fire) begin
                                led_q  <= 1'b1;
                                busy_q <= 1'b1;
                                tcnt   <= TW'(PULSE_TICKS);
                            end
                        end
                    endcase
                end
            end
    end
endmodule

// File: tb/tb_led_blinker.sv
// tb_led_blinker: directed self-checking bench for led_blinker
module tb_led_blinker;
    localparam int NCH = 4;
    localparam int PW  = 4;
    logic pixel_clk = 1'b0;
    logic sys_rst = 1'b0;
    logic [2*NCH-1:0]  mode = '0;
    logic [PW*NCH-1:0] duty = '0;
    logic [NCH-1:0]    trig = '0;
    logic              pixel_rst, tick;
    logic [NCH-1:0]    led, busy;
    int checks = 0;
    int failures = 0;
    always #5 pixel_clk = ~pixel_clk;
    led_blinker #(
        .NCH(NCH), .HALF_PERIOD(32), .CNT_W(27), .PWM_W(PW), .PULSE_TICKS(3)
    ) dut (
        .pixel_clk (pixel_clk),
        .sys_rst   (sys_rst),
        .mode      (mode),
        .duty      (duty),
        .trig      (trig),
        .pixel_rst (pixel_rst),
        .tick      (tick),
        .led       (led),
        .busy      (busy)
    );
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) @(posedge pixel_clk);
        #1;
    endtask
    task automatic wait_tick(input string tag);
        int i = 0;
        while (tick !== 1'b1 && i < 40) begin
            step(1);
            i++;
        end
        check(tag, {31'd0, tick}, 32'd1);
    endtask
    task automatic run_pulse(output int n, output int mm);
        int i = 0;
        n = 0;
        mm = 0;
        while (busy[3] === 1'b1 && i < 200) begin
            if (tick === 1'b1) n++;
            if (led[3] !== busy[3]) mm++;
            step(1);
            i++;
        end
    endtask
    initial begin
        logic l;
        int c0, c1, c2, h3, n, mm;
        #1 sys_rst = 1'b1;
        #1;
        check("rst_async", {31'd0, pixel_rst}, 32'd1);
        check("rst_led", {28'd0, led}, 32'd0);
        check("rst_busy", {28'd0, busy}, 32'd0);
        repeat (5) @(posedge pixel_clk);
        @(negedge pixel_clk) sys_rst = 1'b0;
        step(1);
        check("rst_edge1", {31'd0, pixel_rst}, 32'd1);
        step(1);
        check("rst_edge2", {31'd0, pixel_rst}, 32'd0);
        check("post_rst_led", {28'd0, led}, 32'd0);
        check("post_rst_tick", {31'd0, tick}, 32'd0);
        mode[1:0] = 2'b01;
        wait_tick("blink_tick0");
        l = led[0];
        step(1);
        check("blink_toggle1", {31'd0, led[0]}, {31'd0, ~l});
        check("tick_one_cycle", {31'd0, tick}, 32'd0);
        step(30);
        check("tick_not_early", {31'd0, tick}, 32'd0);
        step(1);
        check("tick_period", {31'd0, tick}, 32'd1);
        check("blink_hold", {31'd0, led[0]}, {31'd0, ~l});
        step(1);
        check("blink_toggle2", {31'd0, led[0]}, {31'd0, l});
        if (led[0] !== 1'b1) step(32);
        check("blink_high", {31'd0, led[0]}, 32'd1);
        mode[1:0] = 2'b00;
        step(1);
        check("blink_to_off", {31'd0, led[0]}, 32'd0);
        mode[1:0] = 2'b01;
        step(1);
        wait_tick("blink_tick1");
        step(1);
        check("blink_high2", {31'd0, led[0]}, 32'd1);
        mode[1:0] = 2'b10;
        duty[3:0] = 4'd15;
        step(1);
        check("mode_change_clear", {31'd0, led[0]}, 32'd0);
        mode = 8'b00_10_10_10;
        duty = {4'd0, 4'd15, 4'd0, 4'd4};
        step(2);
        c0 = 0; c1 = 0; c2 = 0; h3 = 0;
        for (int i = 0; i < 16; i++) begin
            c0 += int'(led[0]);
            c1 += int'(led[1]);
            c2 += int'(led[2]);
            h3 += int'(led[3]) + int'(busy[3]);
            step(1);
        end
        check("pwm_duty4", c0, 32'd4);
        check("pwm_duty0", c1, 32'd0);
        check("pwm_duty15", c2, 32'd15);
        check("pwm_off_ch3", h3, 32'd0);
        mode[7:6] = 2'b11;
        step(2);
        check("pulse_idle", {31'd0, busy[3]}, 32'd0);
        trig[3] = 1'b1;
        step(1);
        check("pulse_start_led", {31'd0, led[3]}, 32'd1);
        check("pulse_start_busy", {31'd0, busy[3]}, 32'd1);
        wait_tick("pulse_tick1");
        step(1);
        trig[3] = 1'b0;
        step(1);
        trig[3] = 1'b1;
        step(1);
        check("retrig_busy", {31'd0, busy[3]}, 32'd1);
        run_pulse(n, mm);
        check("pulse_ticks_left", n, 32'd2);
        check("pulse_end_led", {31'd0, led[3]}, 32'd0);
        check("pulse_led_busy_eq", mm, 32'd0);
        trig[3] = 1'b0;
        step(1);
        wait_tick("align_tick");
        trig[3] = 1'b1;
        step(1);
        check("tick_start_busy", {31'd0, busy[3]}, 32'd1);
        run_pulse(n, mm);
        check("tick_start_ticks", n, 32'd3);
        check("tick_start_eq", mm, 32'd0);
        trig[3] = 1'b0;
        step(1);
        trig[3] = 1'b1;
        step(5);
        check("pre_rst_busy", {31'd0, busy[3]}, 32'd1);
        #2 sys_rst = 1'b1;
        #1;
        check("rst_mid_led", {28'd0, led}, 32'd0);
        check("rst_mid_busy", {28'd0, busy}, 32'd0);
        check("rst_mid_prst", {31'd0, pixel_rst}, 32'd1);
        step(3);
        sys_rst = 1'b0;
        step(40);
        check("no_resume_busy", {28'd0, busy}, 32'd0);
        check("no_resume_led3", {31'd0, led[3]}, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/led_blinker.md
LED_BLINKER -- requirements
Module: led_blinker

Interface
REQ-001 Parameter NCH, default 4, number of LED channels (1..8).
REQ-002 Parameter HALF_PERIOD, default 32000000 (32 under SIMULATION), pixel_clk cycles per tick.
REQ-003 Parameter CNT_W, default 27, prescaler width; SHALL satisfy 2**CNT_W > HALF_PERIOD.
REQ-004 Parameter PWM_W, default 4, PWM counter and duty width.
REQ-005 Parameter PULSE_TICKS, default 3, one-shot length in ticks.
REQ-006 pixel_clk  in  1  clock, 32 MHz.
REQ-007 sys_rst  in  1  reset, asynchronous, active-high.
REQ-008 mode  in  2*NCH  per-channel mode: 00 OFF, 01 BLINK, 10 PWM, 11 PULSE. Synchronous to pixel_clk.
REQ-009 duty  in  PWM_W*NCH  per-channel PWM duty. Synchronous to pixel_clk.
REQ-010 trig  in  NCH  per-channel one-shot request; rising edge active. Synchronous to pixel_clk.
REQ-011 pixel_rst  out  1  sys_rst synchronized to pixel_clk.
REQ-012 tick  out  1  one-cycle prescaler strobe.
REQ-013 led  out  NCH  registered LED drive.
REQ-014 busy  out  NCH  one-shot in progress.

Function
REQ-015 pixel_rst SHALL assert asynchronously with sys_rst and deassert on the 2nd pixel_clk rising edge after sys_rst falls (2-flop synchronizer).
REQ-016 All other state SHALL be reset asynchronously by pixel_rst.
REQ-017 The prescaler SHALL count 0..HALF_PERIOD-1 and wrap to 0; tick=1 exactly in the cycle where the count equals HALF_PERIOD-1.
REQ-018 OFF: led[k]=0, busy[k]=0.
REQ-019 BLINK: led[k] SHALL toggle on the clock edge that ends each tick cycle, giving a period of 2*HALF_PERIOD cycles.
REQ-020 PWM: a shared free-running PWM_W-bit counter SHALL increment every cycle with wrap; led[k] is registered (pwm_cnt < duty[k]). duty=0 gives constant 0. duty=2**PWM_W-1 gives 1 for all counts but one.
REQ-021 PULSE: a channel-local edge detector SHALL produce a one-cycle trigger from a trig[k] 0->1 transition.
REQ-022 In PULSE mode, a trigger while busy[k]=0 SHALL set led[k]=1 and busy[k]=1 on the next edge and load a tick counter with PULSE_TICKS.
REQ-023 The tick counter SHALL decrement on each tick. When it reaches 0, led[k] and busy[k] SHALL clear on that edge.
REQ-024 A trigger while busy[k]=1 SHALL be ignored (no retrigger or extension).
REQ-025 A trigger coinciding with tick while idle SHALL start the pulse. That tick SHALL NOT count.
REQ-026 Any change of mode[k] SHALL clear led[k], busy[k] and the channel tick counter on the next edge. The new mode SHALL take effect from the following cycle.
REQ-027 A trig edge in the same cycle as a mode change SHALL be discarded.
REQ-028 Channels SHALL be independent except for the shared prescaler and PWM counter.

Reset
REQ-029 During pixel_rst the block SHALL hold: prescaler=0, pwm_cnt=0, tick=0, led=0, busy=0, all tick counters=0, edge-detect and previous-mode registers=0.
REQ-030 sys_rst asserted mid-pulse or mid-blink SHALL immediately force led=0 and busy=0. No pulse SHALL resume after release.

Structure
REQ-031 Package led_blinker_pkg SHALL hold the mode_t enum (OFF, BLINK, PWM, PULSE) and the simulation/synthesis HALF_PERIOD constants.
REQ-032 The reset synchronizer SHALL be a separate sub-module, rst_sync.
REQ-033 The per-channel logic SHALL be a generate loop, not a sub-module.

Verification (SIMULATION, HALF_PERIOD=32, NCH=4, PWM_W=4)
REQ-034 Pulse sys_rst for 5 cycles -> pixel_rst=1 immediately; pixel_rst=0 exactly 2 edges after release; led=0.
REQ-035 mode=BLINK on ch0 -> tick every 32 cycles; led[0] toggles on every tick edge; period 64 cycles.
REQ-036 mode=PWM, duty=4/0/15 on ch0/1/2 -> over 16 cycles led[0] high 4, led[1] high 0, led[2] high 15.
REQ-037 mode=PULSE on ch3, trig 0->1 -> led[3] and busy[3] high for 3 ticks. A second trig mid-pulse does not extend it. busy[3] falls with led[3].
REQ-038 BLINK on ch0 with led[0]=1, switch to OFF -> led[0]=0 next edge. sys_rst during an active PULSE -> led=0 and busy=0 asynchronously.
